// File: rtl/VX_wnd_pkg.sv
// Register-window controller shared types.
// Op codes, per-warp state and FSM encoding.
package VX_wnd_pkg;

  localparam int WND_OP_W = 3;

  localparam logic [WND_OP_W-1:0] WND_OP_ENABLE  = 3'd0;
  localparam logic [WND_OP_W-1:0] WND_OP_DISABLE = 3'd1;
  localparam logic [WND_OP_W-1:0] WND_OP_PUSH    = 3'd2;
  localparam logic [WND_OP_W-1:0] WND_OP_POP     = 3'd3;
  localparam logic [WND_OP_W-1:0] WND_OP_FLUSH   = 3'd4;

  localparam int WND_DEF_STEP      = 8;
  localparam int WND_DEF_MAX_DEPTH = 4;
  localparam int WND_DEPTH_W       = $clog2(WND_DEF_MAX_DEPTH);

  typedef struct packed {
    logic                   en;
    logic [WND_DEPTH_W-1:0] depth;
  } wnd_state_t;

  typedef enum logic {
    WND_IDLE,
    WND_FLUSH_ST
  } wnd_fsm_e;

endpackage

// File: rtl/VX_wnd_state_table.sv
// Per-warp window state array.
// One write port, one flush-clear port, bypassed lookup port.
module VX_wnd_state_table
  import VX_wnd_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WID_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WID_W-1:0] waddr_i,
  input  wnd_state_t       wdata_i,
  output wnd_state_t       cur_o,
  input  logic             clr_i,
  input  logic [WID_W-1:0] clr_wid_i,
  input  logic [WID_W-1:0] raddr_i,
  output wnd_state_t       rdata_o
);

  wnd_state_t tbl_q [NUM_WARPS];

  // Warp state storage; flush clears win over op writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (clr_i) begin
      tbl_q[clr_wid_i] <= '0;
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  // Lookup sees the value being written this edge.
  always_comb begin
    cur_o   = tbl_q[waddr_i];
    rdata_o = tbl_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end

endmodule

// File: rtl/vx_wnd_ctrl_unit.sv
// Per-warp register-window controller.
// Applies window ops and feeds wnd_en/offset to decode.
module vx_wnd_ctrl_unit
  import VX_wnd_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WND_STEP  = WND_DEF_STEP,
  parameter int MAX_DEPTH = WND_DEF_MAX_DEPTH,
  parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int OFF_W     = $clog2(MAX_DEPTH * WND_STEP)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WID_W-1:0]    req_wid,
  input  logic [WND_OP_W-1:0] req_op,
  output logic                rsp_valid,
  output logic [WID_W-1:0]    rsp_wid,
  output logic                rsp_fault,
  input  logic                rd_valid,
  input  logic [WID_W-1:0]    rd_wid,
  output logic                dec_valid,
  output logic                dec_wnd_en,
  output logic [OFF_W-1:0]    dec_wnd_offset
);

  localparam int DW = WND_DEPTH_W;

  wnd_fsm_e         state_q, state_d;
  logic [WID_W-1:0] cnt_q;
  logic             last, clr, flush_done;
  logic             accept, acc_op, acc_flush, blank;
  logic             fault;
  wnd_state_t       cur, nxt, rd_st;
  logic             rsp_valid_q, rsp_fault_q;
  logic [WID_W-1:0] rsp_wid_q;
  logic             dec_valid_q, dec_en_q;
  logic [OFF_W-1:0] dec_off_q;

  assign accept    = req_valid && req_ready;
  assign acc_flush = accept && (req_op == WND_OP_FLUSH);
  assign acc_op    = accept && (req_op != WND_OP_FLUSH);
  assign last      = cnt_q == WID_W'(NUM_WARPS - 1);

  VX_wnd_state_table #(
    .NUM_WARPS (NUM_WARPS),
    .WID_W     (WID_W)
  ) u_tbl (
    .clk       (clk),
    .reset     (reset),
    .we_i      (acc_op && !fault),
    .waddr_i   (req_wid),
    .wdata_i   (nxt),
    .cur_o     (cur),
    .clr_i     (clr),
    .clr_wid_i (cnt_q),
    .raddr_i   (rd_wid),
    .rdata_o   (rd_st)
  );

  // Op decode: next warp state and fault.
  always_comb begin
    nxt   = cur;
    fault = 1'b0;
    unique case (1'b1)
      req_op == WND_OP_ENABLE:  nxt.en = 1'b1;
      req_op == WND_OP_DISABLE: nxt.en = 1'b0;
      req_op == WND_OP_PUSH: begin
        if (cur.depth == DW'(MAX_DEPTH - 1)) fault = 1'b1;
        else nxt.depth = cur.depth + DW'(1);
      end
      req_op == WND_OP_POP: begin
        if (cur.depth == '0) fault = 1'b1;
        else nxt.depth = cur.depth - DW'(1);
      end
      req_op == WND_OP_FLUSH: ;
      default: fault = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= WND_IDLE;
    else state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WND_IDLE:     if (acc_flush) state_d = WND_FLUSH_ST;
      WND_FLUSH_ST: if (last) state_d = WND_IDLE;
      default:      state_d = WND_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready  = reset && (state_q == WND_IDLE);
    clr        = state_q == WND_FLUSH_ST;
    flush_done = clr && last;
  end

  // Flush sweep counter.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else if (acc_flush) cnt_q <= '0;
    else if (clr) cnt_q <= cnt_q + WID_W'(1);
  end

  // Completion response, one pulse per op or flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_wid_q   <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      rsp_valid_q <= acc_op || flush_done;
      rsp_wid_q   <= flush_done ? '0 : req_wid;
      rsp_fault_q <= acc_op && fault;
    end
  end

  assign blank = clr || acc_flush;

  // Registered decode lookup, zeroed when idle or flushing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_valid_q <= 1'b0;
      dec_en_q    <= 1'b0;
      dec_off_q   <= '0;
    end else begin
      dec_valid_q <= rd_valid;
      dec_en_q    <= rd_valid && !blank && rd_st.en;
      dec_off_q   <= (rd_valid && !blank)
                   ? OFF_W'(rd_st.depth) * OFF_W'(WND_STEP)
                   : '0;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_wid        = rsp_wid_q;
  assign rsp_fault      = rsp_fault_q;
  assign dec_valid      = dec_valid_q;
  assign dec_wnd_en     = dec_en_q;
  assign dec_wnd_offset = dec_off_q;

endmodule

// File: tb/tb_vx_wnd_ctrl_unit.sv
// Directed bench for the register-window controller.
// Hand-computed vectors plus a small reference model.
module tb_vx_wnd_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_wid;
  logic [2:0] req_op;
  logic       rsp_valid;
  logic [1:0] rsp_wid;
  logic       rsp_fault;
  logic       rd_valid;
  logic [1:0] rd_wid;
  logic       dec_valid;
  logic       dec_wnd_en;
  logic [4:0] dec_wnd_offset;

  int n_chk = 0;
  int n_err = 0;
  int m_en  [4];
  int m_dep [4];

  vx_wnd_ctrl_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wid        (req_wid),
    .req_op         (req_op),
    .rsp_valid      (rsp_valid),
    .rsp_wid        (rsp_wid),
    .rsp_fault      (rsp_fault),
    .rd_valid       (rd_valid),
    .rd_wid         (rd_wid),
    .dec_valid      (dec_valid),
    .dec_wnd_en     (dec_wnd_en),
    .dec_wnd_offset (dec_wnd_offset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int w, input int o, input int ef);
    req_valid = 1'b1;
    req_wid   = w[1:0];
    req_op    = o[2:0];
    step();
    req_valid = 1'b0;
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp_wid", rsp_wid, w);
    chk("op_rsp_fault", rsp_fault, ef);
  endtask

  task automatic lookup(input int w, input int ee, input int eo);
    rd_valid = 1'b1;
    rd_wid   = w[1:0];
    step();
    rd_valid = 1'b0;
    chk("lk_valid", dec_valid, 1);
    chk("lk_en", dec_wnd_en, ee);
    chk("lk_off", dec_wnd_offset, eo);
    step();
    chk("lk_idle_valid", dec_valid, 0);
    chk("lk_idle_en", dec_wnd_en, 0);
    chk("lk_idle_off", dec_wnd_offset, 0);
  endtask

  task automatic model_op(input int w, input int o, output int f);
    f = 0;
    case (o)
      0: m_en[w] = 1;
      1: m_en[w] = 0;
      2: if (m_dep[w] == 3) f = 1; else m_dep[w]++;
      3: if (m_dep[w] == 0) f = 1; else m_dep[w]--;
      default: f = 1;
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int w;
    int o;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_wid   = '0;
    req_op    = '0;
    rd_valid  = 1'b0;
    rd_wid    = '0;
    step();
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dec_valid", dec_valid, 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", req_ready, 1);

    // enable and push twice, lookup offset 16
    do_op(2, 0, 0);
    do_op(2, 2, 0);
    do_op(2, 2, 0);
    step();
    chk("rsp_one_pulse", rsp_valid, 0);
    lookup(2, 1, 16);

    // push overflow and pop underflow
    do_op(1, 2, 0);
    do_op(1, 2, 0);
    do_op(1, 2, 0);
    do_op(1, 2, 1);
    lookup(1, 0, 24);
    do_op(0, 3, 1);
    lookup(0, 0, 0);

    // same-edge bypass
    req_valid = 1'b1;
    req_wid   = 2'd3;
    req_op    = 3'd0;
    rd_valid  = 1'b1;
    rd_wid    = 2'd3;
    step();
    req_valid = 1'b0;
    rd_valid  = 1'b0;
    chk("byp_rsp", rsp_valid, 1);
    chk("byp_en", dec_wnd_en, 1);
    chk("byp_off", dec_wnd_offset, 0);

    // illegal op, no state change
    do_op(2, 6, 1);
    lookup(2, 1, 16);

    // all warps en=1 depth=2, then flush
    do_op(0, 0, 0);
    do_op(0, 2, 0);
    do_op(0, 2, 0);
    do_op(1, 3, 0);
    do_op(1, 0, 0);
    do_op(3, 2, 0);
    do_op(3, 2, 0);
    lookup(3, 1, 16);
    lookup(1, 1, 16);
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_wid   = 2'd1;
    step();
    req_valid = 1'b0;
    chk("fl_ready_t0", req_ready, 0);
    chk("fl_rsp_t0", rsp_valid, 0);
    rd_valid = 1'b1;
    rd_wid   = 2'd3;
    step();
    rd_valid = 1'b0;
    chk("fl_mid_valid", dec_valid, 1);
    chk("fl_mid_en", dec_wnd_en, 0);
    chk("fl_mid_off", dec_wnd_offset, 0);
    chk("fl_ready_t1", req_ready, 0);
    step();
    chk("fl_ready_t2", req_ready, 0);
    chk("fl_rsp_t2", rsp_valid, 0);
    step();
    chk("fl_ready_t3", req_ready, 0);
    chk("fl_rsp_t3", rsp_valid, 0);
    step();
    chk("fl_ready_t4", req_ready, 1);
    chk("fl_rsp_t4", rsp_valid, 1);
    chk("fl_rsp_wid", rsp_wid, 0);
    chk("fl_rsp_fault", rsp_fault, 0);
    step();
    chk("fl_rsp_t5", rsp_valid, 0);
    for (int i = 0; i < 4; i++) lookup(i, 0, 0);

    // reset in the middle of a flush
    do_op(3, 0, 0);
    do_op(3, 2, 0);
    req_valid = 1'b1;
    req_op    = 3'd4;
    step();
    req_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("mr_ready_held", req_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_ready", req_ready, 1);
    chk("mr_rsp", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_stray", rsp_valid, 0);
    end
    for (int i = 0; i < 4; i++) lookup(i, 0, 0);

    // back-to-back ops against the model
    for (int i = 0; i < 4; i++) begin
      m_en[i]  = 0;
      m_dep[i] = 0;
    end
    for (int i = 0; i < 20; i++) begin
      w = $urandom_range(0, 3);
      o = $urandom_range(0, 6);
      if (o == 4) o = 7;
      req_valid = 1'b1;
      req_wid   = w[1:0];
      req_op    = o[2:0];
      model_op(w, o, f);
      step();
      chk("rb_valid", rsp_valid, 1);
      chk("rb_wid", rsp_wid, w);
      chk("rb_fault", rsp_fault, f);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) lookup(i, m_en[i], m_dep[i] * 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
